// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Data is double-buffered and committed at frame boundaries so frames never tear.
module seg_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int DIV         = 50000,
  parameter int BLANK       = 16,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        load,
  input  logic [4*DIGITS-1:0]         din,
  output logic [3:0]                  num,
  output logic [DIGITS-1:0]           dig_sel,
  output logic [$clog2(DIGITS)-1:0]   scan_idx,
  output logic                        frame_done
);

  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST       = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK - 1);
  localparam logic [IW-1:0] IDX_LAST       = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_SHOW
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [4*DIGITS-1:0]   display_q, display_d;
  logic                  pending_q, pending_d;
  logic [3:0]            num_q, num_d;
  logic [DIGITS-1:0]     dig_sel_q, dig_sel_d;
  logic                  frame_done_q, frame_done_d;
  logic                  boundary;

  function automatic logic [3:0] nibble(input logic [4*DIGITS-1:0] d,
                                        input logic [IW-1:0] i);
    return d[4*i +: 4];
  endfunction

  // A digit is dark when it and every more significant digit are zero; digit 0 always shows.
  function automatic logic suppressed(input logic [4*DIGITS-1:0] d,
                                      input logic [IW-1:0] i);
    logic all_zero;
    all_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(i) && d[4*j +: 4] != 4'd0) all_zero = 1'b0;
    end
    return (LZ_SUPPRESS != 0) && (i != '0) && all_zero;
  endfunction

  assign boundary = (state_q == S_SHOW) && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    display_d = display_q;
    pending_d = pending_q;

    if (boundary && (pending_q || load)) begin
      display_d = load ? din : shadow_q;
      pending_d = 1'b0;
    end else if (load) begin
      shadow_d  = din;
      pending_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (en) state_d = S_BLANK;
      end
      S_BLANK: begin
        if (!en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_BLANK_LAST) state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        if (!en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    // Outputs are computed from the next state so they land with it in the same cycle.
    num_d     = nibble(display_d, idx_d);
    dig_sel_d = {DIGITS{1'b1}};
    if (state_d == S_SHOW && !suppressed(display_d, idx_d)) begin
      dig_sel_d = ~(DIGITS'(1) << idx_d);
    end
    frame_done_d = (state_d == S_SHOW) && (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      display_q    <= '0;
      pending_q    <= 1'b0;
      num_q        <= 4'd0;
      dig_sel_q    <= {DIGITS{1'b1}};
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      display_q    <= display_d;
      pending_q    <= pending_d;
      num_q        <= num_d;
      dig_sel_q    <= dig_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign num        = num_q;
  assign dig_sel    = dig_sel_q;
  assign scan_idx   = idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: DIGITS=4, DIV=8, BLANK=2, with a second
// instance using LZ_SUPPRESS=0 driven by the same inputs.
module tb_seg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int BLANK  = 2;

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [15:0] din;
  logic [3:0]  num, num_n;
  logic [3:0]  dig_sel, dig_sel_n;
  logic [1:0]  scan_idx, scan_idx_n;
  logic        frame_done, frame_done_n;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK), .LZ_SUPPRESS(1)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .din(din),
    .num(num), .dig_sel(dig_sel), .scan_idx(scan_idx), .frame_done(frame_done)
  );

  seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK), .LZ_SUPPRESS(0)) dut_nlz (
    .clk(clk), .rst(rst), .en(en), .load(load), .din(din),
    .num(num_n), .dig_sel(dig_sel_n), .scan_idx(scan_idx_n), .frame_done(frame_done_n)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the edge, and load is a one-edge strobe.
  task automatic tick();
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic check_slot(input string fr, input int s, input logic [3:0] exp_num,
                            input bit shown, input bit ld_end, input logic [15:0] ld_val);
    logic [3:0] one_hot;
    logic [3:0] exp_sel;
    logic [3:0] exp_sel_n;
    one_hot = 4'b0001 << s;
    for (int k = 0; k < DIV; k++) begin
      tick();
      exp_sel   = (k >= BLANK && shown) ? ~one_hot : 4'b1111;
      exp_sel_n = (k >= BLANK) ? ~one_hot : 4'b1111;
      chk($sformatf("%s_s%0d_k%0d_idx", fr, s, k), 16'(scan_idx), 16'(s));
      chk($sformatf("%s_s%0d_k%0d_num", fr, s, k), 16'(num), 16'(exp_num));
      chk($sformatf("%s_s%0d_k%0d_sel", fr, s, k), 16'(dig_sel), 16'(exp_sel));
      chk($sformatf("%s_s%0d_k%0d_fd", fr, s, k), 16'(frame_done),
          16'((s == DIGITS - 1) && (k == DIV - 1)));
      chk($sformatf("%s_s%0d_k%0d_sel_nlz", fr, s, k), 16'(dig_sel_n), 16'(exp_sel_n));
    end
    if (ld_end) begin
      load = 1'b1;
      din  = ld_val;
    end
  endtask

  task automatic check_frame(input string fr, input logic [15:0] disp, input logic [3:0] mask,
                             input bit ld_end, input logic [15:0] ld_val);
    for (int s = 0; s < DIGITS; s++) begin
      check_slot(fr, s, disp[4*s +: 4], mask[s], ld_end && (s == DIGITS - 1), ld_val);
    end
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    load = 1'b0;
    din  = 16'h0000;
    tick();
    tick();
    rst = 1'b0;

    // Reset / idle: dark display for 50 cycles
    for (int i = 0; i < 50; i++) begin
      tick();
      chk($sformatf("idle%0d_sel", i), 16'(dig_sel), 16'h000F);
      chk($sformatf("idle%0d_num", i), 16'(num), 16'h0000);
      chk($sformatf("idle%0d_fd", i), 16'(frame_done), 16'h0000);
      chk($sformatf("idle%0d_idx", i), 16'(scan_idx), 16'h0000);
      chk($sformatf("idle%0d_sel_nlz", i), 16'(dig_sel_n), 16'h000F);
    end

    // Basic scan: 4321 stays pending until the first boundary
    load = 1'b1;
    din  = 16'h4321;
    tick();
    chk("preen_sel", 16'(dig_sel), 16'h000F);
    en = 1'b1;
    check_frame("F1", 16'h0000, 4'b0001, 1'b0, 16'h0000);
    check_frame("F2", 16'h4321, 4'b1111, 1'b0, 16'h0000);

    // Tear-free: mid-frame load of 1111 only appears in the next frame
    check_slot("F3", 0, 4'd1, 1'b1, 1'b0, 16'h0000);
    check_slot("F3", 1, 4'd2, 1'b1, 1'b0, 16'h0000);
    load = 1'b1;
    din  = 16'h1111;
    check_slot("F3", 2, 4'd3, 1'b1, 1'b0, 16'h0000);
    check_slot("F3", 3, 4'd4, 1'b1, 1'b0, 16'h0000);
    // Load coincident with frame_done commits at that same boundary
    check_frame("F4", 16'h1111, 4'b1111, 1'b1, 16'h0050);

    // Leading-zero suppression and out-of-range values
    check_frame("F5", 16'h0050, 4'b0011, 1'b1, 16'hFA00);
    check_frame("F6", 16'hFA00, 4'b1111, 1'b1, 16'h0000);
    check_frame("F7", 16'h0000, 4'b0001, 1'b1, 16'h4321);

    // Abort: drop en during SHOW of digit 2
    check_slot("F8", 0, 4'd1, 1'b1, 1'b0, 16'h0000);
    check_slot("F8", 1, 4'd2, 1'b1, 1'b0, 16'h0000);
    tick();
    tick();
    tick();
    chk("abort_pre_sel", 16'(dig_sel), 16'h000B);
    chk("abort_pre_idx", 16'(scan_idx), 16'h0002);
    en = 1'b0;
    tick();
    chk("abort_sel", 16'(dig_sel), 16'h000F);
    chk("abort_idx", 16'(scan_idx), 16'h0000);
    chk("abort_fd", 16'(frame_done), 16'h0000);
    chk("abort_sel_nlz", 16'(dig_sel_n), 16'h000F);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("abort_idle%0d_sel", i), 16'(dig_sel), 16'h000F);
      chk($sformatf("abort_idle%0d_idx", i), 16'(scan_idx), 16'h0000);
    end
    en = 1'b1;
    check_slot("F9", 0, 4'd1, 1'b1, 1'b0, 16'h0000);
    check_slot("F9", 1, 4'd2, 1'b1, 1'b0, 16'h0000);

    // Reset mid-slot with a pending load: the load is discarded
    load = 1'b1;
    din  = 16'h9999;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_num", 16'(num), 16'h0000);
    chk("rst_sel", 16'(dig_sel), 16'h000F);
    chk("rst_idx", 16'(scan_idx), 16'h0000);
    chk("rst_fd", 16'(frame_done), 16'h0000);
    rst = 1'b0;
    check_frame("F10", 16'h0000, 4'b0001, 1'b0, 16'h0000);
    check_frame("F11", 16'h0000, 4'b0001, 1'b0, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
